// File: rtl/tmr_voter_pipe_if.sv
// Bundle of the voter's sample inputs and vote outputs.
// The master side supplies channel words and controls; the slave side is the voter.
interface tmr_voter_pipe_if #(
   parameter int N_CH  = 5,
   parameter int WIDTH = 8
);
   logic                    in_valid;
   logic [N_CH*WIDTH-1:0]   in_data;
   logic                    force_one;
   logic                    clr_fault;
   logic                    out_valid;
   logic [WIDTH-1:0]        out_data;
   logic                    unanimous;
   logic [N_CH-1:0]         dis_mask;
   logic [N_CH-1:0]         fault;

   modport master (
      output in_valid, in_data, force_one, clr_fault,
      input  out_valid, out_data, unanimous, dis_mask, fault
   );

   modport slave (
      input  in_valid, in_data, force_one, clr_fault,
      output out_valid, out_data, unanimous, dis_mask, fault
   );
endinterface

// File: rtl/tmr_voter_pipe.sv
// N-channel bitwise threshold voter, two pipeline stages, with per-channel
// disagreement tracking that raises a sticky fault after FAULT_LIM
// consecutive disagreeing results.
module tmr_voter_pipe #(
   parameter int N_CH      = 5,
   parameter int WIDTH     = 8,
   parameter int THRESH    = (N_CH + 1) / 2,
   parameter int FAULT_LIM = 4
) (
   input  logic           clk,
   input  logic           rst,
   tmr_voter_pipe_if.slave bus
);

   localparam int CW = $clog2(N_CH + 1);
   localparam int FW = $clog2(FAULT_LIM + 1);

   typedef logic [FW-1:0] cnt_t;

   // Bitwise vote: a result bit is 1 when at least THRESH channels carry a 1.
   function automatic logic [WIDTH-1:0] vote(input logic [N_CH*WIDTH-1:0] d);
      logic [CW-1:0]    ones;
      logic [WIDTH-1:0] v;
      v = '0;
      for (int b = 0; b < WIDTH; b++) begin
         ones = '0;
         for (int i = 0; i < N_CH; i++) begin
            ones = ones + CW'(d[i*WIDTH + b]);
         end
         v[b] = (ones >= CW'(THRESH));
      end
      return v;
   endfunction

   // Saturating increment of a disagreement counter.
   function automatic cnt_t sat_inc(input cnt_t c);
      return (c == cnt_t'(FAULT_LIM)) ? c : c + cnt_t'(1);
   endfunction

   logic                  vld_p1;
   logic [N_CH*WIDTH-1:0] data_p1;
   logic                  force_p1;

   logic                  vld_p2;
   logic [WIDTH-1:0]      data_p2;
   logic [N_CH-1:0]       dis_p2;
   logic                  unan_p2;

   logic [WIDTH-1:0]      raw_vote;
   logic [N_CH-1:0]       dis_now;
   cnt_t                  cnt_q   [N_CH];
   cnt_t                  cnt_nxt [N_CH];
   logic [N_CH-1:0]       fault_q;

   // Stage 1: capture the sample; data holds while no sample is offered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1   <= 1'b0;
         data_p1  <= '0;
         force_p1 <= 1'b0;
      end else begin
         vld_p1 <= bus.in_valid;
         if (bus.in_valid) begin
            data_p1  <= bus.in_data;
            force_p1 <= bus.force_one;
         end
      end
   end

   // Raw vote and per-channel disagreement against the pre-force vote.
   always_comb begin
      raw_vote = vote(data_p1);
      dis_now  = '0;
      for (int i = 0; i < N_CH; i++) begin
         dis_now[i] = (data_p1[i*WIDTH +: WIDTH] != raw_vote);
      end
   end

   // Next counter values: count consecutive disagreements, reset on agreement.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         cnt_nxt[i] = dis_now[i] ? sat_inc(cnt_q[i]) : '0;
      end
   end

   // Stage 2: register the forced vote, mask and unanimity for each result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p2  <= 1'b0;
         data_p2 <= '0;
         dis_p2  <= '0;
         unan_p2 <= 1'b0;
      end else begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            data_p2 <= raw_vote | {WIDTH{force_p1}};
            dis_p2  <= dis_now;
            unan_p2 <= (dis_now == '0);
         end
      end
   end

   // Fault tracking: clear wins over a coincident result; fault is sticky.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
         fault_q <= '0;
      end else if (bus.clr_fault) begin
         for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
         fault_q <= '0;
      end else if (vld_p1) begin
         for (int i = 0; i < N_CH; i++) begin
            cnt_q[i] <= cnt_nxt[i];
            if (cnt_nxt[i] == cnt_t'(FAULT_LIM)) fault_q[i] <= 1'b1;
         end
      end
   end

   assign bus.out_valid = vld_p2;
   assign bus.out_data  = data_p2;
   assign bus.dis_mask  = dis_p2;
   assign bus.unanimous = unan_p2;
   assign bus.fault     = fault_q;

endmodule
